// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The flush feature of imem_responder is enabled by defining IMEM_FLUSH_EN.
package imem_pkg;

    localparam int          IMEM_WORD_W = 32;
    localparam logic [31:0] IMEM_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_IDLE,
        IMEM_WAIT,
        IMEM_RESP
    } imem_state_e;

    // A fetch is bad when it is not word aligned or points past the last stored word.
    function automatic logic imem_addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous load (write) port and one synchronous
// read port. A read and a write to the same word in one cycle return the old word.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [IMEM_WORD_W-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [IMEM_WORD_W-1:0] rd_data
);

    logic [IMEM_WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; nonblocking update gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the IF stage: valid/ready fetch handshake,
// WAIT_CYCLES memory wait states, error response for bad addresses, and a
// program-load write port. Define IMEM_FLUSH_EN to add the flush input.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic                     rsp_err,
`ifdef IMEM_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

    imem_state_e          state;
    logic [3:0]           cnt;
    logic [AW-1:0]        addr_q;
    logic                 err_q;
    logic                 flush_act;
    logic                 req_bad;
    logic                 accept;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [31:0]          rd_data;

`ifdef IMEM_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign req_bad = imem_addr_bad(req_addr, DEPTH);
    assign accept  = req_valid && req_ready;

    // Ready in IDLE, and in RESP only for zero-wait back-to-back while the response drains.
    always_comb begin
        req_ready = 1'b0;
        case (state)
            IMEM_IDLE: req_ready = 1'b1;
            IMEM_RESP: req_ready = ZERO_WAIT && rsp_ready && !flush_act;
            default:   req_ready = 1'b0;
        endcase
    end

    // Read on the last wait state, or directly at acceptance when there are no wait states.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = req_addr[AW+1:2];
        if (state == IMEM_WAIT) begin
            rd_en   = (cnt == 4'd1) && !err_q;
            rd_addr = addr_q;
        end else begin
            rd_en = accept && ZERO_WAIT && !req_bad;
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Bad fetches and idle cycles present the NOP; good responses show the array word.
    assign rsp_instr = (rsp_valid && !rsp_err) ? rd_data : IMEM_NOP;

    // Fetch FSM with wait counter and registered response flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IMEM_IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (flush_act && (state != IMEM_IDLE)) begin
            state     <= IMEM_IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IMEM_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr[AW+1:2];
                        err_q  <= req_bad;
                        cnt    <= WAIT_LD;
                        if (ZERO_WAIT) begin
                            state     <= IMEM_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_bad;
                        end else begin
                            state <= IMEM_WAIT;
                        end
                    end
                end
                IMEM_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= IMEM_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                    end
                end
                IMEM_RESP: begin
                    if (rsp_ready) begin
                        if (accept) begin
                            addr_q  <= req_addr[AW+1:2];
                            err_q   <= req_bad;
                            rsp_err <= req_bad;
                        end else begin
                            state     <= IMEM_IDLE;
                            rsp_valid <= 1'b0;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IMEM_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with two wait states and one with
// none, checked against a word-array model of the program image.
module tb_imem_responder;

    localparam int          DEPTH = 16;
    localparam int          WAITS = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_rsp_instr;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_rsp_instr;
`ifdef IMEM_FLUSH_EN
    logic        a_flush, b_flush;
`endif

    logic [31:0] model_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_addr  (a_req_addr),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_instr (a_rsp_instr),
        .rsp_err   (a_rsp_err),
`ifdef IMEM_FLUSH_EN
        .flush     (a_flush),
`endif
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_zero (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_addr  (b_req_addr),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_instr (b_rsp_instr),
        .rsp_err   (b_rsp_err),
`ifdef IMEM_FLUSH_EN
        .flush     (b_flush),
`endif
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bad(input logic [31:0] addr);
        return ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] addr);
        if (exp_bad(addr)) return NOP;
        return model_mem[addr / 4];
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, DEPTH - 1) * 4);
            2:       return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic load_word(input int idx, input logic [31:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 4'(idx);
        ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
        load_word(4, 32'h0020_8133);
    endtask

    // One fetch on the two-wait-state instance, holding the response for 'hold' cycles.
    task automatic fetch_a(input logic [31:0] addr, input int hold, input string tag);
        logic [31:0] exp_i;
        logic        exp_e;
        int          lat;
        exp_i = exp_instr(addr);
        exp_e = exp_bad(addr);
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        a_rsp_ready = 1'b0;
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s req_ready idle got %b want 1", tag, a_req_ready);
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (a_rsp_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != WAITS + 1) begin
            errors++;
            $display("[TB] FAIL %s latency got %0d want %0d", tag, lat, WAITS + 1);
        end
        checks++;
        if (a_rsp_instr !== exp_i || a_rsp_err !== exp_e) begin
            errors++;
            $display("[TB] FAIL %s response got %h/%b want %h/%b", tag, a_rsp_instr, a_rsp_err, exp_i, exp_e);
        end
        for (int i = 0; i < hold; i++) begin
            a_req_valid = 1'b1;
            a_req_addr  = rand_addr();
            #1;
            checks++;
            if (a_req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s stall req_ready got %b want 0", tag, a_req_ready);
            end
            @(negedge clk);
            checks++;
            if (a_rsp_valid !== 1'b1 || a_rsp_instr !== exp_i) begin
                errors++;
                $display("[TB] FAIL %s stall hold got %b/%h want 1/%h", tag, a_rsp_valid, a_rsp_instr, exp_i);
            end
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s drain got valid %b ready %b want 0 1", tag, a_rsp_valid, a_req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_instr !== NOP) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b/%b/%h want 0/0/%h", a_rsp_valid, a_rsp_err, a_rsp_instr, NOP);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_instr !== NOP) begin
            errors++;
            $display("[TB] FAIL reset_release got %b/%b/%b/%h want 1/1/0/%h", a_req_ready, b_req_ready, b_rsp_valid, b_rsp_instr, NOP);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_addr  = 32'h8;
        @(negedge clk);
        a_req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_rsp_instr !== NOP) begin
            errors++;
            $display("[TB] FAIL reset_mid got %b/%h want 0/%h", a_rsp_valid, a_rsp_instr, NOP);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_ready got %b want 1", a_req_ready);
        end
        for (int i = 0; i < WAITS + 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid_no_rsp cycle %0d got %b want 0", i, a_rsp_valid);
            end
        end
    endtask

    task automatic test_latency();
        fetch_a(32'h10, 0, "latency_word4");
    endtask

    task automatic test_errors();
        fetch_a(32'h12, 0, "err_misaligned");
        fetch_a(32'(4 * DEPTH), 0, "err_range");
    endtask

    task automatic test_stall();
        fetch_a(32'h10, 5, "stall");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) fetch_a(rand_addr(), $urandom_range(0, 2), "random");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [$];
        addrs = '{32'h0, 32'h4, 32'h8, 32'hc};
        for (int i = 0; i < 12; i++) addrs.push_back(rand_addr());
        b_rsp_ready = 1'b1;
        for (int i = 0; i <= addrs.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (b_rsp_valid !== 1'b1 || b_rsp_instr !== exp_instr(addrs[i-1]) || b_rsp_err !== exp_bad(addrs[i-1])) begin
                    errors++;
                    $display("[TB] FAIL b2b_rsp %0d got %b/%h/%b want 1/%h/%b", i - 1, b_rsp_valid, b_rsp_instr, b_rsp_err, exp_instr(addrs[i-1]), exp_bad(addrs[i-1]));
                end
            end
            if (i < addrs.size()) begin
                checks++;
                if (b_req_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready %0d got %b want 1", i, b_req_ready);
                end
                b_req_valid = 1'b1;
                b_req_addr  = addrs[i];
            end else begin
                b_req_valid = 1'b0;
            end
        end
        @(negedge clk);
        b_rsp_ready = 1'b0;
        checks++;
        if (b_rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain got %b want 0", b_rsp_valid);
        end
    endtask

    task automatic test_collision();
        int          k;
        logic [31:0] old_w, new_w;
        k     = $urandom_range(0, DEPTH - 1);
        old_w = model_mem[k];
        new_w = ~old_w;
        @(negedge clk);
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        b_req_addr  = 32'(k * 4);
        ld_en       = 1'b1;
        ld_addr     = 4'(k);
        ld_data     = new_w;
        @(negedge clk);
        ld_en       = 1'b0;
        b_req_valid = 1'b0;
        model_mem[k] = new_w;
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_instr !== old_w) begin
            errors++;
            $display("[TB] FAIL collision_old got %b/%h want 1/%h", b_rsp_valid, b_rsp_instr, old_w);
        end
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_addr  = 32'(k * 4);
        @(negedge clk);
        b_req_valid = 1'b0;
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_instr !== new_w) begin
            errors++;
            $display("[TB] FAIL collision_new got %b/%h want 1/%h", b_rsp_valid, b_rsp_instr, new_w);
        end
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

`ifdef IMEM_FLUSH_EN
    task automatic test_flush();
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_addr  = 32'h4;
        @(negedge clk);
        a_req_valid = 1'b0;
        a_flush     = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        for (int i = 0; i < WAITS + 3; i++) begin
            checks++;
            if (a_rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_wait cycle %0d got %b want 0", i, a_rsp_valid);
            end
            @(negedge clk);
        end
        b_req_valid = 1'b1;
        b_req_addr  = 32'h0;
        b_rsp_ready = 1'b0;
        @(negedge clk);
        b_req_addr  = 32'h8;
        b_rsp_ready = 1'b1;
        b_flush     = 1'b1;
        #1;
        checks++;
        if (b_req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_ready got %b want 0", b_req_ready);
        end
        @(negedge clk);
        b_flush     = 1'b0;
        b_req_valid = 1'b0;
        b_rsp_ready = 1'b0;
        checks++;
        if (b_rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_resp got %b want 0", b_rsp_valid);
        end
        fetch_a(32'h0, 0, "after_flush");
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst         = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        a_req_valid = 1'b0;
        a_req_addr  = '0;
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0;
        b_req_addr  = '0;
        b_rsp_ready = 1'b0;
`ifdef IMEM_FLUSH_EN
        a_flush = 1'b0;
        b_flush = 1'b0;
`endif
        test_reset();
        load_all();
        test_reset_mid_wait();
        test_latency();
        test_errors();
        test_stall();
        test_random();
        test_back_to_back();
        test_collision();
`ifdef IMEM_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the fetch-side counterpart that supplies 32-bit instructions to the pipelined RISC-V `microprocessor` IF stage. Accepts one fetch request at a time over a valid/ready handshake, models a configurable number of memory wait states, and returns the instruction word or an error. Also carries a write port so a bench or boot loader can load the program image.

## Interface
- `DEPTH`, 256: instruction words stored; power of two, ≥ 4.
- `WAIT_CYCLES`, 1: wait states between request acceptance and response; 0–15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  responder accepts request this cycle.
- `req_addr`  in  32  byte address of instruction.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  IF stage consumes response this cycle.
- `rsp_instr`  out  32  instruction word.
- `rsp_err`  out  1  misaligned or out-of-range fetch.
- `ld_en`  in  1  program-load write strobe.
- `ld_addr`  in  $clog2(DEPTH)  word index for load.
- `ld_data`  in  32  load data.
- `flush`  in  1  drop in-flight fetch (only with `IMEM_FLUSH_EN`).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch address, load counter with `WAIT_CYCLES`; go WAIT (or RESP if `WAIT_CYCLES`=0).
- WAIT: decrement counter each cycle; at counter==1 read array, go RESP.
- RESP: `rsp_valid`=1, outputs stable until `rsp_ready`. On `rsp_ready`: if `req_valid` also high and `WAIT_CYCLES`=0, `req_ready`=1 in RESP and the new request is accepted in the same cycle (back-to-back, one instruction per cycle); otherwise go IDLE.
- Error: `req_addr[1:0]`≠0 or `req_addr[31:2]`≥`DEPTH` → `rsp_err`=1, `rsp_instr`=32'h0000_0013 (NOP); array not read. Same latency as a good fetch.
- Load port: `ld_en` writes `ld_data` to word `ld_addr` in any state. Write and read of the same word in one cycle: read returns old data.
- Array contents not reset.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `req_ready`=1 after reset release, `rsp_valid`=0, `rsp_err`=0, `rsp_instr`=32'h0000_0013, counter 0.
- Request accepted at edge N → `rsp_valid` high after edge N+1+`WAIT_CYCLES`... i.e. visible in cycle N+1+`WAIT_CYCLES`.
- `WAIT_CYCLES`=0: throughput one response per cycle while `rsp_ready`=1.
- `rsp_ready`=0: response held, no new request accepted (`req_ready`=0 outside IDLE except the RESP rule above).
- Reset mid-operation: in-flight fetch discarded, no response emitted.

## Configuration
- `IMEM_FLUSH_EN` defined: `flush` port present. `flush`=1 forces IDLE next cycle from WAIT or RESP, `rsp_valid` drops next cycle, no response for the flushed fetch; `req_ready`=0 while `flush`=1 (no request accepted in the flush cycle). Flush in IDLE has no effect.
- Not defined: no `flush` port; every accepted request produces exactly one response.

## Structure
- `imem_pkg`: state enum (`IMEM_IDLE`, `IMEM_WAIT`, `IMEM_RESP`), `IMEM_NOP` = 32'h0000_0013, word-width constant 32.
- Sub-module `imem_array`: DEPTH×32 storage, one sync write port (load), one sync read port; read-before-write on collision.
- Top holds FSM, wait counter, address/err checking, handshake.

## Test plan
- Reset: hold `rst`=0 mid-WAIT → `rsp_valid`=0, `rsp_instr`=32'h0000_0013, `req_ready`=1 after release.
- Load word 4 = 32'h0020_8133, `WAIT_CYCLES`=2, request addr 0x10 at cycle N → `rsp_valid` at N+3, `rsp_instr`=32'h0020_8133, `rsp_err`=0.
- Request addr 0x12 and addr 4×`DEPTH` → `rsp_err`=1, `rsp_instr`=32'h0000_0013, same latency.
- `WAIT_CYCLES`=0, addresses 0,4,8,12 back-to-back with `rsp_ready`=1 → four responses on consecutive cycles in order.
- `rsp_ready`=0 for 5 cycles in RESP → `rsp_instr` stable, `req_ready`=0, no new request taken.
- `IMEM_FLUSH_EN`: flush in WAIT → no response; next request at addr 0x0 returns word 0 normally.
